uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive path for the user-project UART on mprj_io[5], which the bench UART drives (8N1, LSB first, idle high).
//  Block: 2-flop input synchroniser -> start-bit-validated deserialiser -> small FWFT RX FIFO.
//  FIFO drains via valid/ready to the Wishbone register slave, which firmware polls.
//  Framing and overrun errors are sticky status bits.
// PARAMETERS
//  CLKS_PER_BIT  4167  wb_clk_i cycles per bit (40 MHz / 9600); must be >= 8
//  FIFO_DEPTH    4     RX FIFO entries; power of 2, >= 2
// PORTS
//  wb_clk_i      in   1    single clock for the whole block
//  wb_rst_i      in   1    reset, asynchronous, active-high
//  rx_i          in   1    serial input (async to wb_clk_i)
//  rx_data_o     out  8    FIFO head byte; valid only while rx_valid_o=1
//  rx_valid_o    out  1    FIFO not empty
//  rx_ready_i    in   1    consumer pops head when rx_valid_o && rx_ready_i
//  fifo_level_o  out  $clog2(FIFO_DEPTH)+1  number of entries held
//  frame_err_o   out  1    sticky: a stop bit was sampled as 0
//  overrun_o     out  1    sticky: a byte was dropped because the FIFO was full
//  clear_err_i   in   1    1-cycle pulse; clears both sticky flags
// BEHAVIOUR
//  Reset: sync flops=1, state=IDLE, counters=0, FIFO empty.
//   rx_valid_o=0, fifo_level_o=0, rx_data_o=8'h00, frame_err_o=0, overrun_o=0.
//   An asserted reset mid-frame aborts the frame; the partial byte is lost.
//  Synchroniser: rx_s = rx_i delayed 2 flops. rx_q = rx_s delayed 1 flop, used for edge detect.
//  FSM: IDLE, START, DATA, STOP. bit_cnt counts 0..CLKS_PER_BIT-1; bit_idx counts 0..7.
//   IDLE:  rx_q=1 && rx_s=0 (falling edge) -> START, bit_cnt=0.
//   START: at bit_cnt==CLKS_PER_BIT/2-1, sample rx_s.
//          0 -> DATA, bit_cnt=0, bit_idx=0. 1 -> IDLE (glitch reject, no flag).
//   DATA:  at bit_cnt==CLKS_PER_BIT-1, shift rx_s into shreg[7] (right shift, LSB first).
//          bit_idx==7 -> STOP; otherwise bit_idx+1. All sampling is mid-bit.
//   STOP:  at bit_cnt==CLKS_PER_BIT-1, sample rx_s.
//          1 -> push shreg into the FIFO. 0 -> discard byte, set frame_err_o.
//          Both cases -> IDLE. A held-low break gives no new start until the line returns high (edge detect).
//  Latency: push occurs on the stop-sample cycle; rx_valid_o rises 1 cycle later.
//   rx_i fall to rx_valid_o rise = 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (+1 for the push register).
//  FIFO: first-word fall-through; rx_data_o = mem[rd_ptr].
//   Pointers carry an extra wrap bit; empty = ptrs equal, full = MSB differs and rest equal.
//   Pop: rx_valid_o && rx_ready_i; rd_ptr+1. A pop while empty is ignored.
//   Push while full with no pop that cycle: byte dropped, overrun_o set, contents unchanged.
//   Push and pop in the same cycle: both happen, including when full; level unchanged.
//  Sticky flags: set has priority over clear_err_i in the same cycle.
//  rx_ready_i may be held high continuously; throughput is then limited only by the line rate.
// STRUCTURE
//  Shared package uart_pkg: FSM state encodings (2-bit), UART_DATA_BITS=8, default CLKS_PER_BIT.
//   The TX block reuses this package.
//  One sub-module: uart_sync_fifo #(WIDTH=8, DEPTH=FIFO_DEPTH).
//   Ports: clk, rst, push, push_data, pop, head, empty, full, level.
//   Async active-high reset, same as parent.
//  Top contains the synchroniser, counters, FSM, and flag logic.
// TESTING (CLKS_PER_BIT=16, FIFO_DEPTH=4; bench serialises at 16 clk/bit)
//  1. Send 8'h0F, rx_ready_i=1 -> one valid pulse with rx_data_o=8'h0F, flags 0, level back to 0.
//  2. Send 8'h0F then 8'h3D back-to-back, rx_ready_i=0 -> level=2, head 8'h0F.
//     Pop -> head 8'h3D, level=1.
//  3. Low glitch of 4 clks on an idle line -> no push, FSM returns to IDLE, no flags.
//     A following 8'hA5 is received correctly.
//  4. Send 8'h55 with stop bit forced 0 -> level stays 0, frame_err_o=1.
//     Pulse clear_err_i -> frame_err_o=0.
//  5. Send 6 bytes 8'h01..8'h06, rx_ready_i=0 -> level=4, FIFO holds 01..04, overrun_o=1.
//     Pop all -> 01,02,03,04 in order.
//  6. Assert wb_rst_i during DATA of 8'hC3 -> all outputs reset immediately.
//     After release, 8'h3C is received intact.
//  Also: pop while full in the same cycle as a push -> no overrun, level stays 4.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame format, default bit timing and FSM state encodings.
// Used by both the RX and TX paths.
package uart_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 4167;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers.
// A push is accepted when full only if a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];

  // NOTE: the storage is reset because the head byte is architecturally visible
  // and must read as zero after reset; at this depth the cost is negligible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
      // so push and pop in the same cycle see a consistent pointer pair.
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule : uart_sync_fifo

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receive path: 2-flop synchroniser, mid-bit sampling deserialiser,
// FWFT RX FIFO with valid/ready drain and sticky framing/overrun flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          rx_i,
  output logic [UART_DATA_BITS-1:0]     rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          frame_err_o,
  output logic                          overrun_o,
  input  logic                          clear_err_i
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST = 3'(UART_DATA_BITS - 1);

  logic rx_meta, rx_s, rx_q;

  uart_state_e               state, state_d;
  logic [CNT_W-1:0]          bit_cnt, bit_cnt_d;
  logic [2:0]                bit_idx, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shreg, shreg_d;
  logic                      push, frame_err_set, overrun_set;
  logic                      pop, fifo_empty, fifo_full;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start edge.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      rx_q    <= rx_s;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      bit_idx <= bit_idx_d;
      shreg   <= shreg_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d       = state;
    bit_cnt_d     = bit_cnt + CNT_ONE;
    bit_idx_d     = bit_idx;
    shreg_d       = shreg;
    push          = 1'b0;
    frame_err_set = 1'b0;
    unique case (state)
      IDLE: begin
        bit_cnt_d = '0;
        if (rx_q && !rx_s) state_d = START;
      end
      START: begin
        if (bit_cnt == CNT_HALF) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_cnt == CNT_FULL) begin
          bit_cnt_d = '0;
          shreg_d   = {rx_s, shreg[UART_DATA_BITS-1:1]};
          if (bit_idx == IDX_LAST) state_d = STOP;
          else                     bit_idx_d = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (bit_cnt == CNT_FULL) begin
          bit_cnt_d     = '0;
          state_d       = IDLE;
          push          = rx_s;
          frame_err_set = !rx_s;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_valid_o  = !fifo_empty;
  assign pop         = rx_valid_o && rx_ready_i;
  assign overrun_set = push && fifo_full && !pop;

  // Setting wins over clearing so an error in the clear cycle is never lost.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      if (frame_err_set)    frame_err_o <= 1'b1;
      else if (clear_err_i) frame_err_o <= 1'b0;
      if (overrun_set)      overrun_o   <= 1'b1;
      else if (clear_err_i) overrun_o   <= 1'b0;
    end
  end

  uart_sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (push),
    .push_data (shreg),
    .pop       (pop),
    .head      (rx_data_o),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level_o)
  );

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit and a 4-entry FIFO.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_i = 1'b1;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i = 1'b0;
  logic [2:0] fifo_level_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       clear_err_i = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [7:0] popped [$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .rx_i         (rx_i),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .fifo_level_o (fifo_level_o),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .clear_err_i  (clear_err_i)
  );

  // Record every byte the consumer takes; sampled mid low-phase, well clear of both edges.
  always @(negedge clk) begin
    #2;
    if (rx_valid_o && rx_ready_i) popped.push_back(rx_data_o);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Called at a negedge; drives one 8N1 frame, one bit per CPB clocks.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_i = stop_bit;
    repeat (CPB) @(negedge clk);
    rx_i = 1'b1;
  endtask

  task automatic pop_one();
    rx_ready_i = 1'b1;
    @(negedge clk);
    rx_ready_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_errors();
    clear_err_i = 1'b1;
    @(negedge clk);
    clear_err_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++; if (rx_valid_o !== 1'b0)    begin tests_failed++; $display("FAIL reset_valid: got %b want 0", rx_valid_o); end
    tests_run++; if (fifo_level_o !== 3'd0)  begin tests_failed++; $display("FAIL reset_level: got %0d want 0", fifo_level_o); end
    tests_run++; if (rx_data_o !== 8'h00)    begin tests_failed++; $display("FAIL reset_data: got %h want 00", rx_data_o); end
    tests_run++; if (frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin tests_failed++; $display("FAIL reset_flags: got fe=%b ov=%b want 0 0", frame_err_o, overrun_o); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_byte();
    popped.delete();
    rx_ready_i = 1'b1;
    send_frame(8'h0F, 1'b1);
    repeat (4) @(negedge clk);
    rx_ready_i = 1'b0;
    tests_run++; if (popped.size() != 1) begin tests_failed++; $display("FAIL single_count: got %0d pops want 1", popped.size()); end
    else begin
      tests_run++; if (popped[0] !== 8'h0F) begin tests_failed++; $display("FAIL single_data: got %h want 0f", popped[0]); end
    end
    tests_run++; if (fifo_level_o !== 3'd0) begin tests_failed++; $display("FAIL single_level: got %0d want 0", fifo_level_o); end
    tests_run++; if (frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin tests_failed++; $display("FAIL single_flags: got fe=%b ov=%b want 0 0", frame_err_o, overrun_o); end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h0F, 1'b1);
    send_frame(8'h3D, 1'b1);
    repeat (2) @(negedge clk);
    tests_run++; if (fifo_level_o !== 3'd2) begin tests_failed++; $display("FAIL b2b_level: got %0d want 2", fifo_level_o); end
    tests_run++; if (rx_data_o !== 8'h0F)   begin tests_failed++; $display("FAIL b2b_head0: got %h want 0f", rx_data_o); end
    pop_one();
    tests_run++; if (rx_data_o !== 8'h3D)   begin tests_failed++; $display("FAIL b2b_head1: got %h want 3d", rx_data_o); end
    tests_run++; if (fifo_level_o !== 3'd1) begin tests_failed++; $display("FAIL b2b_level1: got %0d want 1", fifo_level_o); end
    pop_one();
  endtask

  task automatic test_glitch();
    rx_i = 1'b0;
    repeat (4) @(negedge clk);
    rx_i = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    tests_run++; if (fifo_level_o !== 3'd0) begin tests_failed++; $display("FAIL glitch_level: got %0d want 0", fifo_level_o); end
    tests_run++; if (frame_err_o !== 1'b0)  begin tests_failed++; $display("FAIL glitch_flag: got %b want 0", frame_err_o); end
    send_frame(8'hA5, 1'b1);
    repeat (2) @(negedge clk);
    tests_run++; if (fifo_level_o !== 3'd1 || rx_data_o !== 8'hA5) begin tests_failed++; $display("FAIL glitch_follow: got level=%0d head=%h want 1 a5", fifo_level_o, rx_data_o); end
    pop_one();
  endtask

  task automatic test_frame_error();
    send_frame(8'h55, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    tests_run++; if (fifo_level_o !== 3'd0) begin tests_failed++; $display("FAIL ferr_level: got %0d want 0", fifo_level_o); end
    tests_run++; if (frame_err_o !== 1'b1)  begin tests_failed++; $display("FAIL ferr_set: got %b want 1", frame_err_o); end
    clear_errors();
    tests_run++; if (frame_err_o !== 1'b0)  begin tests_failed++; $display("FAIL ferr_clear: got %b want 0", frame_err_o); end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 6; i++) send_frame(8'(i), 1'b1);
    repeat (2) @(negedge clk);
    tests_run++; if (fifo_level_o !== 3'd4) begin tests_failed++; $display("FAIL ovr_level: got %0d want 4", fifo_level_o); end
    tests_run++; if (overrun_o !== 1'b1)    begin tests_failed++; $display("FAIL ovr_flag: got %b want 1", overrun_o); end
    popped.delete();
    repeat (4) pop_one();
    tests_run++; if (popped.size() != 4) begin tests_failed++; $display("FAIL ovr_count: got %0d pops want 4", popped.size()); end
    else for (int i = 0; i < 4; i++) begin
      tests_run++; if (popped[i] !== 8'(i + 1)) begin tests_failed++; $display("FAIL ovr_order%0d: got %h want %h", i, popped[i], 8'(i + 1)); end
    end
    clear_errors();
    tests_run++; if (overrun_o !== 1'b0) begin tests_failed++; $display("FAIL ovr_clear: got %b want 0", overrun_o); end
  endtask

  // The 5th byte's stop sample lands on the 155th rising edge after its start
  // bit is driven (2 sync + 1 edge detect + 8 half bit + 9 bits of 16).
  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1);
    popped.delete();
    fork
      send_frame(8'h15, 1'b1);
      begin
        repeat (154) @(negedge clk);
        rx_ready_i = 1'b1;
        @(negedge clk);
        rx_ready_i = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    tests_run++; if (fifo_level_o !== 3'd4) begin tests_failed++; $display("FAIL fullpp_level: got %0d want 4", fifo_level_o); end
    tests_run++; if (overrun_o !== 1'b0)    begin tests_failed++; $display("FAIL fullpp_overrun: got %b want 0", overrun_o); end
    repeat (4) pop_one();
    tests_run++; if (popped.size() != 5) begin tests_failed++; $display("FAIL fullpp_count: got %0d pops want 5", popped.size()); end
    else for (int i = 0; i < 5; i++) begin
      tests_run++; if (popped[i] !== 8'h11 + 8'(i)) begin tests_failed++; $display("FAIL fullpp_order%0d: got %h want %h", i, popped[i], 8'h11 + 8'(i)); end
    end
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'h99, 1'b1);
    send_frame(8'h00, 1'b0);
    repeat (2) @(negedge clk);
    fork
      send_frame(8'hC3, 1'b1);
      begin
        repeat (60) @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++; if (rx_valid_o !== 1'b0 || fifo_level_o !== 3'd0) begin tests_failed++; $display("FAIL midrst_fifo: got valid=%b level=%0d want 0 0", rx_valid_o, fifo_level_o); end
        tests_run++; if (rx_data_o !== 8'h00) begin tests_failed++; $display("FAIL midrst_data: got %h want 00", rx_data_o); end
        tests_run++; if (frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin tests_failed++; $display("FAIL midrst_flags: got fe=%b ov=%b want 0 0", frame_err_o, overrun_o); end
      end
    join
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    send_frame(8'h3C, 1'b1);
    repeat (2) @(negedge clk);
    tests_run++; if (fifo_level_o !== 3'd1 || rx_data_o !== 8'h3C) begin tests_failed++; $display("FAIL midrst_after: got level=%0d head=%h want 1 3c", fifo_level_o, rx_data_o); end
    tests_run++; if (frame_err_o !== 1'b0) begin tests_failed++; $display("FAIL midrst_after_flag: got %b want 0", frame_err_o); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_full_push_pop();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_uart_rx_fifo
